capture_ctrl: RTL
=================

# capture_ctrl

Capture sequencer between the `trigger` output stream and the sample-memory writer. It is programmed over the same write-only system bus as `trigger`. It arms on command and forwards samples while armed. On a selected trigger event it counts a programmed number of post-trigger samples, then marks the last sample with `tlast` and stops. Status and a one-cycle interrupt report completion to the host.

## Interface
- `BAW`, 8: bus address width
- `BDW`, 32: bus data width
- `SDW`, 32: sample data width
- `SEW`, 2: sample event width (matches `trigger`)
- `CCW`, 16: post-trigger counter width (CCW <= BDW)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `bus_wready`  out  1  bus write ready
- `bus_wvalid`  in  1  bus write valid
- `bus_waddr`  in  BAW  register address
- `bus_wdata`  in  BDW  write data
- `sti_tready`  out  1  input stream ready (to `trigger` sto)
- `sti_tvalid`  in  1  input stream valid
- `sti_tevent`  in  SEW  event flags for the sample
- `sti_tdata`  in  SDW  sample
- `sto_tready`  in  1  output stream ready (from memory writer)
- `sto_tvalid`  out  1  output stream valid
- `sto_tlast`  out  1  last sample of capture
- `sto_tdata`  out  SDW  sample
- `sts_state`  out  2  FSM state: 0 IDLE, 1 ARMED, 2 POST, 3 DONE
- `irq`  out  1  one-cycle pulse when the FSM enters DONE

## Operation
- Registers are written on `bus_wvalid & bus_wready`. Unmapped addresses are ignored.
  - 0x00 CTRL (write-only pulses): bit0 ARM, bit1 ABORT.
  - 0x01 POST: `wdata[CCW-1:0]`, post-trigger sample count N.
  - 0x02 EVSEL: `wdata[SEW-1:0]`, event mask.
- Writes to POST or EVSEL are ignored unless the state is IDLE or DONE.
- Transfer definitions:
  - Input transfer = `sti_tvalid & sti_tready`.
  - Output transfer = `sto_tvalid & sto_tready`.
  - Hit = input transfer with `(sti_tevent & EVSEL) != 0`.
- IDLE:
  - `sti_tready=1`; input samples are discarded; `sto_tvalid=0`.
  - ARM -> ARMED.
- ARMED:
  - Pass-through: `sto_tvalid=sti_tvalid`, `sti_tready=sto_tready`, `sto_tdata=sti_tdata`.
  - Hit with N=0: the hit sample is output with `tlast=1`, then -> DONE.
  - Hit with N>0: counter loads N, the hit sample is output with `tlast=0`, then -> POST.
- POST:
  - Pass-through; each transfer decrements the counter. Events are ignored.
  - The transfer taken while counter==1 carries `tlast=1`, then -> DONE.
  - Total samples output after arming = pre-trigger samples + 1 + N.
- DONE:
  - Behaves as IDLE for the streams. `irq=1` for the first cycle only.
  - ARM -> ARMED.
- ARM written while in ARMED or POST is ignored.
- ABORT in any state -> IDLE next cycle, with no `tlast` emitted.
  - ABORT arriving in the same cycle as a hit or the last POST transfer still wins: the state goes to IDLE and `irq` is not raised. That sample's transfer still completes on the output, including its tlast value.
  - ABORT and ARM in the same write: ABORT wins.
- EVSEL=0: a hit can never occur; ARMED forwards indefinitely until ABORT.
- Counter is CCW bits; N = 2^CCW-1 must work without wrap.

## Timing
- Reset values (`rst`=0, asynchronous):
  - `bus_wready=0`, `sti_tready=0`, `sto_tvalid=0`, `sto_tlast=0`, `sto_tdata=0`, `sts_state=0`, `irq=0`.
  - POST=0, EVSEL=0, counter=0.
- After reset release, `bus_wready` rises on the first clock edge and stays 1.
- A register write takes effect on the clock edge that accepts it.
  - ARM accepted at edge k: `sts_state`=1 after edge k; samples are forwarded from cycle k+1.
- Data path has zero latency (combinational pass-through). `sto_tlast` is combinational from state, counter and `sti_tevent`.
- State changes on the edge of the qualifying transfer. `irq` is a registered pulse, high for exactly the one cycle following that edge.
- Backpressure: while `sto_tready=0` in ARMED or POST, `sti_tready=0`; state and counter hold.
- Reset asserted mid-capture forces IDLE asynchronously. The partial capture is lost and no `tlast` is emitted.

## Test plan
- Write POST=3, EVSEL=1, ARM. Send samples 0x10..0x1F with the event on 0x14.
  - Expected: output 0x10..0x17, `tlast` only on 0x17; DONE; one `irq` pulse; later inputs are discarded with `sti_tready=1`.
- POST=0, EVSEL=2, event bit1 on 0x22.
  - Expected: 0x22 output with `tlast=1` and state DONE; event bit0 on earlier samples does not trigger.
- Toggle `sto_tready` randomly (50%) during scenario 1.
  - Expected: identical output sequence, no loss or duplication, counter holds while stalled.
- ABORT during POST with 2 samples remaining.
  - Expected: state IDLE next cycle, no `tlast`, no `irq`; a subsequent POST write is accepted and a re-ARM captures correctly.
- Write POST=5 while ARMED.
  - Expected: write ignored, old N is used.
- ARM while in DONE: re-arms, and `irq` fires again on completion.
- Assert `rst` low mid-POST.
  - Expected: all outputs at their reset values immediately; after release, `bus_wready=1` after 1 edge.

Source files
------------

// File: rtl/capture_ctrl_if.sv
// ============================================================================
// capture_ctrl_if : bus write port plus input and output sample streams
// Revision 1.0
// ============================================================================
`default_nettype none

interface capture_ctrl_if #(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2
);
  logic           bus_wready;
  logic           bus_wvalid;
  logic [BAW-1:0] bus_waddr;
  logic [BDW-1:0] bus_wdata;

  logic           sti_tready;
  logic           sti_tvalid;
  logic [SEW-1:0] sti_tevent;
  logic [SDW-1:0] sti_tdata;

  logic           sto_tready;
  logic           sto_tvalid;
  logic           sto_tlast;
  logic [SDW-1:0] sto_tdata;

  modport slave (
    output bus_wready, sti_tready, sto_tvalid, sto_tlast, sto_tdata,
    input  bus_wvalid, bus_waddr, bus_wdata,
    input  sti_tvalid, sti_tevent, sti_tdata, sto_tready
  );

  modport master (
    input  bus_wready, sti_tready, sto_tvalid, sto_tlast, sto_tdata,
    output bus_wvalid, bus_waddr, bus_wdata,
    output sti_tvalid, sti_tevent, sti_tdata, sto_tready
  );
endinterface

`default_nettype wire

// File: rtl/capture_ctrl.sv
// ============================================================================
// capture_ctrl : arm / trigger / post-trigger capture sequencer with irq
// Revision 1.0
// ============================================================================
`default_nettype none

module capture_ctrl #(
  parameter int BAW = 8,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int CCW = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  capture_ctrl_if.slave   ifc,
  output logic [1:0]      sts_state,
  output logic            irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [BAW-1:0] ADDR_CTRL  = BAW'(0);
  localparam logic [BAW-1:0] ADDR_POST  = BAW'(1);
  localparam logic [BAW-1:0] ADDR_EVSEL = BAW'(2);

  state_t         state, state_nxt;
  logic           up;
  logic [CCW-1:0] post_n, cnt, cnt_nxt;
  logic [SEW-1:0] evsel;
  logic           wr, arm, abort, cfg_ok, pass, ev_match, xfer_in;
  logic           unused_wdata;

  assign unused_wdata = ^ifc.bus_wdata[BDW-1:CCW];

  // bus_wready and sti_tready stay low until the first edge after reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) up <= 1'b0;
    else      up <= 1'b1;
  end

  assign ifc.bus_wready = up;
  assign wr     = ifc.bus_wvalid & up;
  assign arm    = wr && (ifc.bus_waddr == ADDR_CTRL) && ifc.bus_wdata[0];
  assign abort  = wr && (ifc.bus_waddr == ADDR_CTRL) && ifc.bus_wdata[1];
  assign cfg_ok = (state == S_IDLE) || (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      post_n <= '0;
      evsel  <= '0;
    end else if (wr && cfg_ok) begin
      if (ifc.bus_waddr == ADDR_POST)  post_n <= ifc.bus_wdata[CCW-1:0];
      if (ifc.bus_waddr == ADDR_EVSEL) evsel  <= ifc.bus_wdata[SEW-1:0];
    end
  end

  assign pass           = (state == S_ARMED) || (state == S_POST);
  assign ifc.sti_tready = up & (pass ? ifc.sto_tready : 1'b1);
  assign ifc.sto_tvalid = pass & ifc.sti_tvalid;
  assign ifc.sto_tdata  = pass ? ifc.sti_tdata : '0;
  assign ev_match       = |(ifc.sti_tevent & evsel);
  assign xfer_in        = ifc.sti_tvalid & ifc.sti_tready;
  assign ifc.sto_tlast  = ((state == S_ARMED) && ev_match && (post_n == '0)) ||
                          ((state == S_POST) && (cnt == CCW'(1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      irq   <= (state_nxt == S_DONE) && (state != S_DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_DONE: begin
        if (arm) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (xfer_in && ev_match) begin
          if (post_n == '0) begin
            state_nxt = S_DONE;
          end else begin
            cnt_nxt   = post_n;
            state_nxt = S_POST;
          end
        end
      end
      S_POST: begin
        if (xfer_in) begin
          cnt_nxt = cnt - CCW'(1);
          if (cnt == CCW'(1)) state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Abort overrides every other transition, including completion
    if (abort) state_nxt = S_IDLE;
  end

  assign sts_state = state;

endmodule

`default_nettype wire
